// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 framing definitions for the receiver and the transmitter.
//   FRAME_BITS  - start + 8 data + parity + stop
//   DATA_BITS   - payload width, LSB sent first
//   ps2_state_t - deframing FSM states
//   odd_parity  - parity bit that makes the count of ones in {byte, bit} odd
package ps2_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: brings an asynchronous PS/2 pin into the CLKOUT domain and
// debounces it.
//   CLKOUT  in  system clock, rising edge
//   reset_n in  synchronous active-low reset (all state returns to idle-high)
//   pin     in  asynchronous pin
//   level   out filtered level; flips only after FILTER_LEN consecutive
//               synchronised samples disagree with it
//   fall    out one-cycle pulse in the cycle after level went 1 -> 0
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLKOUT,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLKOUT) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            fall  <= 1'b0;
            // cnt tracks how many samples in a row have differed from level;
            // any agreeing sample restarts the run, so short glitches vanish.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync2;
                cnt   <= '0;
                fall  <= level;   // old level 1 means this is a 1 -> 0 change
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/recibirps2.sv
// recibirps2: PS/2 frame receiver. Deframes start(0), 8 data bits LSB first,
// odd parity and stop(1) into bytes.
//   CLKOUT     in  system clock, rising edge
//   reset_n    in  synchronous active-low reset; drops any partial frame
//   ps2_clk    in  PS/2 clock pin (asynchronous)
//   ps2_data   in  PS/2 data pin (asynchronous)
//   d_out      out last good byte, held until the next good frame
//   valid      out 1-cycle strobe, d_out just updated
//   parity_err out 1-cycle strobe, parity wrong, d_out unchanged
//   frame_err  out 1-cycle strobe, stop bit 0 or inter-edge timeout
//   busy       out high from accepted start bit until frame end/abort
// Handshake: valid/parity_err/frame_err are fire-and-forget strobes with no
// ready; the consumer must capture d_out in the cycle valid is high. At most
// one strobe is high in any cycle.
module recibirps2
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 CLKOUT,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int BW = $clog2(DATA_BITS);

    // The filtered clock level itself is not needed here; only its edge is.
    logic unused_clk_level;
    logic clk_fall;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .CLKOUT (CLKOUT),
        .reset_n(reset_n),
        .pin    (ps2_clk),
        .level  (unused_clk_level),
        .fall   (clk_fall)
    );

    // Data only needs synchronising: it is stable for the whole clock-low
    // phase, long before the filtered fall arrives.
    logic data_s1;
    logic data_s2;

    ps2_state_t           state;
    logic [DATA_BITS-1:0] sr;
    logic                 par;
    logic [BW-1:0]        bit_cnt;
    logic [TW-1:0]        tcnt;

    always_ff @(posedge CLKOUT) begin
        if (!reset_n) begin
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            state      <= IDLE;
            sr         <= '0;
            par        <= 1'b0;
            bit_cnt    <= '0;
            tcnt       <= '0;
            d_out      <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_s1    <= ps2_data;
            data_s2    <= data_s1;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            // An edge always beats a simultaneous timeout.
            if (clk_fall) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        sr      <= {data_s2, sr[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= data_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        // A bad stop bit outranks a parity error.
                        if (!data_s2) begin
                            frame_err <= 1'b1;
                        end else if (par == odd_parity(sr)) begin
                            d_out <= sr;
                            valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // Saturates at the limit; the next start-bit edge clears it.
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    frame_err <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_recibirps2.sv
// tb_recibirps2: directed bench for the PS/2 receiver.
// CLKOUT period 2 ns, FILTER_LEN=4, TIMEOUT_CYC=200, PS/2 bit period 60 ns.
`timescale 1ns/1ps
module tb_recibirps2;

    localparam int FL = 4;
    localparam int TO = 200;

    logic       CLKOUT = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] d_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc           = 0;
    int         n_valid       = 0;
    int         n_perr        = 0;
    int         n_ferr        = 0;
    int         last_ferr_cyc = 0;
    logic       busy_at_valid = 1'b1;
    logic [2:0] prev_flags    = 3'b000;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #1 CLKOUT = ~CLKOUT;
    always @(posedge CLKOUT) cyc++;

    recibirps2 #(
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLKOUT    (CLKOUT),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .d_out     (d_out),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard / pulse monitor, sampled on the falling edge.
    always @(negedge CLKOUT) begin
        if (valid | parity_err | frame_err) begin
            check("one_flag", $countones({valid, parity_err, frame_err}), 1);
            check("pulse_1cyc", {29'b0, prev_flags & {valid, parity_err, frame_err}}, 0);
        end
        if (valid) begin
            n_valid++;
            busy_at_valid = busy;
            if (exp_q.size() == 0)
                check("exp_q_nonempty", {24'b0, d_out}, 32'h100);
            else
                check("d_out_scb", {24'b0, d_out}, {24'b0, exp_q.pop_front()});
        end
        if (parity_err) n_perr++;
        if (frame_err) begin
            n_ferr++;
            last_ferr_cyc = cyc;
        end
        prev_flags = {valid, parity_err, frame_err};
    end

    // ---------------- driver tasks ----------------
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic p, input logic stop);
        return {stop, p, b, 1'b0};
    endfunction

    // Sends frame bits first..last (bit 0 = start). Delays are even so the
    // driver stays aligned to falling CLKOUT edges.
    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2_data = f[i];
            #16 ps2_clk = 1'b0;
            #30 ps2_clk = 1'b1;
            #14;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLKOUT);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int v0, p0, f0, t_end;
        logic [10:0] f;

        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        check("rst_d_out", {24'b0, d_out}, 32'h00);
        check("rst_flags", {29'b0, valid, parity_err, frame_err}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        reset_n = 1'b1;
        wait_cycles(10);

        // Good frame 0x0C: two ones -> parity 1
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        exp_q.push_back(8'h0C);
        f = mk_frame(8'h0C, 1'b1, 1'b1);
        send_bits(f, 0, 3);
        check("busy_mid", {31'b0, busy}, 1);
        send_bits(f, 4, 10);
        wait_cycles(20);
        check("t2_valid_cnt", n_valid - v0, 1);
        check("t2_err_cnt", (n_perr - p0) + (n_ferr - f0), 0);
        check("t2_d_out", {24'b0, d_out}, 32'h0C);
        check("t2_busy_at_valid", {31'b0, busy_at_valid}, 0);

        // 0xFF with parity 0 (should be 1)
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_bits(mk_frame(8'hFF, 1'b0, 1'b1), 0, 10);
        wait_cycles(20);
        check("t3_perr_cnt", n_perr - p0, 1);
        check("t3_valid_cnt", n_valid - v0, 0);
        check("t3_ferr_cnt", n_ferr - f0, 0);
        check("t3_d_out_held", {24'b0, d_out}, 32'h0C);

        // 0x1C, correct parity 0, but stop bit 0
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 0, 10);
        ps2_data = 1'b1;
        wait_cycles(20);
        check("t4_ferr_cnt", n_ferr - f0, 1);
        check("t4_valid_cnt", n_valid - v0, 0);
        check("t4_perr_cnt", n_perr - p0, 0);
        check("t4_d_out_held", {24'b0, d_out}, 32'h0C);

        // Truncated frame: start + 3 data bits, then clock stays high
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_bits(mk_frame(8'hA5, 1'b1, 1'b1), 0, 3);
        ps2_data = 1'b1;
        t_end = cyc;
        for (int k = 0; k < 300; k++) begin
            if (n_ferr != f0) break;
            @(negedge CLKOUT);
        end
        check("t5_timeout_ferr", n_ferr - f0, 1);
        check("t5_timeout_window",
              {31'b0, (last_ferr_cyc - t_end >= 178) && (last_ferr_cyc - t_end <= 192)}, 1);
        check("t5_busy_after", {31'b0, busy}, 0);
        check("t5_no_valid", n_valid - v0, 0);
        // 0xF0: four ones -> parity 1
        v0 = n_valid;
        exp_q.push_back(8'hF0);
        send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 0, 10);
        wait_cycles(20);
        check("t5_valid_cnt", n_valid - v0, 1);
        check("t5_d_out", {24'b0, d_out}, 32'hF0);

        // Glitch in IDLE
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        ps2_clk = 1'b0;
        #2 ps2_clk = 1'b1;
        wait_cycles(20);
        check("t6_idle_glitch_pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        check("t6_idle_glitch_busy", {31'b0, busy}, 0);
        // Mid-frame glitch, then reset during bit 5
        f = mk_frame(8'h5A, 1'b1, 1'b1);
        send_bits(f, 0, 2);
        #4 ps2_clk = 1'b0;
        #2 ps2_clk = 1'b1;
        send_bits(f, 3, 5);
        check("t6_busy_before_rst", {31'b0, busy}, 1);
        ps2_data = f[6];
        #16 ps2_clk = 1'b0;
        #4  reset_n = 1'b0;
        #26 ps2_clk = 1'b1;
        #20 reset_n = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(20);
        check("t6_rst_pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        check("t6_rst_busy", {31'b0, busy}, 0);
        check("t6_rst_d_out", {24'b0, d_out}, 32'h00);
        // 0x5A: four ones -> parity 1
        v0 = n_valid;
        exp_q.push_back(8'h5A);
        send_bits(f, 0, 10);
        wait_cycles(20);
        check("t6_valid_cnt", n_valid - v0, 1);
        check("t6_d_out", {24'b0, d_out}, 32'h5A);
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
